// File: rtl/ros2_buf_arbiter.sv
// ros2_buf_arbiter
// Round-robin ownership arbiter for one buffer shared between the CPU
// (requester 0 by convention) and the ROS2 IP requesters. A requester holds
// a level request until granted, keeps exclusive ownership until it pulses
// its release bit, and then has to wait behind every other pending requester.
//
// Optional feature: define ROS2_BUF_ARB_WATCHDOG_EN to build the hold
// watchdog, which revokes a grant held for i_timeout cycles (0 = never).
// Without the macro, i_timeout is ignored and the timeout outputs read 0.
//
// Ports
//   clk             clock
//   rst             asynchronous active-high reset
//   i_enable        arbiter enable; low masks grants and ends ownership
//   i_req           level request per requester
//   i_rel           single-cycle release pulse per requester
//   o_grant         registered one-hot grant, masked by i_enable
//   o_busy          ownership currently held (masked by i_enable)
//   o_owner         index of the current or most recent owner
//   i_timeout       watchdog hold limit in cycles, latched at grant
//   o_timeout_pulse one-cycle pulse after a watchdog revoke
//   o_timeout_id    requester whose grant was revoked
module ros2_buf_arbiter #(
  parameter int N_REQ     = 2,
  parameter int TIMEOUT_W = 16,
  localparam int OWNER_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ-1:0]     i_rel,
  output logic [N_REQ-1:0]     o_grant,
  output logic                 o_busy,
  output logic [OWNER_W-1:0]   o_owner,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  output logic                 o_timeout_pulse,
  output logic [OWNER_W-1:0]   o_timeout_id
);

  typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

  state_t             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [OWNER_W-1:0] r_owner;
  logic [OWNER_W-1:0] r_last;
  logic [OWNER_W:0]   w_pick;
  logic               w_expire;

  // Returns {found, index} of the first request at or after last+1,
  // wrapping. Scanning offsets downward lets the nearest offset win.
  function automatic logic [OWNER_W:0] rr_pick(input logic [N_REQ-1:0]   req,
                                               input logic [OWNER_W-1:0] last);
    logic [OWNER_W:0] res;
    logic [N_REQ-1:0] sh;
    int idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      sh  = req >> idx;
      if (sh[0]) res = {1'b1, OWNER_W'(idx)};
    end
    return res;
  endfunction

  assign w_pick = rr_pick(i_req, r_last);

`ifdef ROS2_BUF_ARB_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] r_limit;
  logic                 r_tpulse;
  logic [OWNER_W-1:0]   r_tid;

  // Counter starts at 0 on the first owned cycle, so reaching limit-1
  // means the grant has been visible for exactly `limit` cycles.
  assign w_expire        = (r_limit != '0) && (r_cnt == r_limit - TIMEOUT_W'(1));
  assign o_timeout_pulse = r_tpulse;
  assign o_timeout_id    = r_tid;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^i_timeout;
  assign w_expire         = 1'b0;
  assign o_timeout_pulse  = 1'b0;
  assign o_timeout_id     = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_last   <= OWNER_W'(N_REQ - 1);
`ifdef ROS2_BUF_ARB_WATCHDOG_EN
      r_cnt    <= '0;
      r_limit  <= '0;
      r_tpulse <= 1'b0;
      r_tid    <= '0;
`endif
    end else begin
`ifdef ROS2_BUF_ARB_WATCHDOG_EN
      r_tpulse <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (i_enable && w_pick[OWNER_W]) begin
            r_state <= S_OWNED;
            r_grant <= N_REQ'(1) << w_pick[OWNER_W-1:0];
            r_owner <= w_pick[OWNER_W-1:0];
`ifdef ROS2_BUF_ARB_WATCHDOG_EN
            r_cnt   <= '0;
            r_limit <= i_timeout;
`endif
          end
        end
        S_OWNED: begin
          if (!i_enable || i_rel[r_owner] || w_expire) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= r_owner;
`ifdef ROS2_BUF_ARB_WATCHDOG_EN
            // A release or disable on the expiry edge wins over the watchdog.
            if (i_enable && !i_rel[r_owner]) begin
              r_tpulse <= 1'b1;
              r_tid    <= r_owner;
            end
`endif
          end
`ifdef ROS2_BUF_ARB_WATCHDOG_EN
          else if (r_cnt != '1) begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant = r_grant & {N_REQ{i_enable}};
  assign o_busy  = (r_state == S_OWNED) & i_enable;
  assign o_owner = r_owner;

endmodule

// File: tb/tb_ros2_buf_arbiter.sv
module tb_ros2_buf_arbiter;

  localparam int N = 2;
`ifdef ROS2_BUF_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [1:0]  i_req = '0;
  logic [1:0]  i_rel = '0;
  logic [15:0] i_timeout = '0;
  logic [1:0]  o_grant;
  logic        o_busy;
  logic [0:0]  o_owner;
  logic        o_timeout_pulse;
  logic [0:0]  o_timeout_id;

  ros2_buf_arbiter #(.N_REQ(N), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_req(i_req), .i_rel(i_rel),
    .o_grant(o_grant), .o_busy(o_busy), .o_owner(o_owner),
    .i_timeout(i_timeout), .o_timeout_pulse(o_timeout_pulse),
    .o_timeout_id(o_timeout_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    logic       b;
    int         own;
    logic       p;
    int         tid;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: owner is -1 when nobody holds the buffer; held counts
  // cycles the grant has been visible; a grant lives at most lim cycles.
  int m_own, m_last, m_disp, m_held, m_lim, m_tid;
  bit m_pulse;

  task automatic m_reset();
    m_own = -1; m_last = N - 1; m_disp = 0; m_held = 0; m_lim = 0;
    m_tid = 0; m_pulse = 0;
  endtask

  function automatic exp_t m_outputs(input logic en);
    exp_t e;
    e.g   = (m_own >= 0 && en) ? 2'(1 << m_own) : 2'b00;
    e.b   = (m_own >= 0) && en;
    e.own = m_disp;
    e.p   = m_pulse;
    e.tid = m_tid;
    return e;
  endfunction

  task automatic m_edge(input logic [1:0] req, input logic [1:0] rel,
                        input logic en, input logic [15:0] tmo);
    bit np;
    bit relo;
    int i;
    np = 0;
    if (m_own >= 0) begin
      m_held++;
      relo = ((rel >> m_own) & 2'b01) != 0;
      if (!en || relo || (WD && m_lim != 0 && m_held == m_lim)) begin
        if (en && !relo) begin np = 1; m_tid = m_own; end
        m_last = m_own;
        m_own  = -1;
      end
    end else if (en && req != 0) begin
      for (int k = 1; k <= N; k++) begin
        i = (m_last + k) % N;
        if (((req >> i) & 2'b01) != 0) begin
          m_own = i; m_disp = i; m_held = 0; m_lim = int'(tmo);
          break;
        end
      end
    end
    m_pulse = np;
  endtask

  task automatic step(input logic r, input logic [1:0] req, input logic [1:0] rel,
                      input logic en, input logic [15:0] tmo);
    @(posedge clk);
    #1;
    rst = r; i_req = req; i_rel = rel; i_enable = en; i_timeout = tmo;
    q.push_back(m_outputs(en));
    if (r) m_reset();
    else m_edge(req, rel, en, tmo);
  endtask

  // Reset asserted between edges must clear the grant without a clock.
  task automatic rst_mid(input logic [1:0] req);
    exp_t e;
    @(posedge clk);
    #1;
    i_req = req; i_rel = '0; i_enable = 1'b1;
    e = m_outputs(1'b1);
    #1;
    chk("grant_before_async_rst", 32'(o_grant), 32'(e.g));
    rst = 1'b1;
    #1;
    chk("grant_async_rst", 32'(o_grant), 32'd0);
    chk("busy_async_rst", 32'(o_busy), 32'd0);
    m_reset();
    q.push_back(m_outputs(1'b1));
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("grant", 32'(o_grant), 32'(e.g));
      chk("busy", 32'(o_busy), 32'(e.b));
      chk("owner", 32'(o_owner), 32'(e.own));
      chk("timeout_pulse", 32'(o_timeout_pulse), 32'(e.p));
      chk("timeout_id", 32'(o_timeout_id), 32'(e.tid));
    end
  end

  initial begin
    m_reset();
    step(1, 2'b00, 2'b00, 1, 0);
    step(1, 2'b00, 2'b00, 1, 0);
    // Both request from cycle 0; requester 0 released at cycle 5.
    for (int c = 0; c < 8; c++)
      step(0, 2'b11, (c == 5) ? 2'b01 : 2'b00, 1, 0);
    // Requester 1 owns: foreign release ignored, own release hands to 0.
    step(0, 2'b11, 2'b01, 1, 0);
    step(0, 2'b11, 2'b00, 1, 0);
    step(0, 2'b11, 2'b10, 1, 0);
    step(0, 2'b11, 2'b00, 1, 0);
    step(0, 2'b11, 2'b00, 1, 0);
    // Release 0, then requester 1 alone with a 4-cycle limit and no release.
    step(0, 2'b10, 2'b01, 1, 4);
    for (int c = 0; c < 9; c++) step(0, 2'b10, 2'b00, 1, 4);
    // Release on the 4th owned cycle wins over the watchdog.
    step(0, 2'b00, 2'b10, 1, 4);
    step(0, 2'b00, 2'b00, 1, 4);
    step(0, 2'b01, 2'b00, 1, 4);
    for (int c = 0; c < 3; c++) step(0, 2'b01, 2'b00, 1, 4);
    step(0, 2'b01, 2'b01, 1, 4);
    step(0, 2'b00, 2'b00, 1, 4);
    // Enable drop while owned, then re-enable.
    step(0, 2'b01, 2'b00, 1, 0);
    step(0, 2'b01, 2'b00, 1, 0);
    step(0, 2'b01, 2'b00, 0, 0);
    step(0, 2'b01, 2'b00, 0, 0);
    for (int c = 0; c < 4; c++) step(0, 2'b01, 2'b00, 1, 0);
    // Long hold with a short limit, then asynchronous reset mid-hold.
    step(0, 2'b00, 2'b01, 1, 2);
    for (int c = 0; c < 100; c++) step(0, 2'b10, 2'b00, 1, 2);
    rst_mid(2'b10);
    step(1, 2'b10, 2'b00, 1, 2);
    for (int c = 0; c < 4; c++) step(0, 2'b11, 2'b00, 1, 2);
    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [1:0] rq, rl;
      logic en;
      rq = 2'($urandom_range(0, 3));
      rl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      en = ($urandom_range(0, 11) != 0);
      step(0, rq, rl, en, 16'($urandom_range(0, 6)));
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
